bcd_countdown_timer: RTL and testbench

- Two-digit synchronous BCD down-counter (99..00) with parallel load, start/pause control and a one-cycle terminal pulse.
- It is the down-counting counterpart to the lab's BCD up-counters. It drives countdown displays and timeout events.
- Decrements happen only on an external tick strobe, so a prescaler sits upstream.

---
 rtl/bcd_countdown_timer.sv | 124 ++++++++++++
 tb/tb_bcd_countdown_timer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_countdown_timer.sv
// ============================================================================
// Module      : bcd_countdown_timer
// Description : Two-digit BCD down-counter (99..00) with sanitized parallel
//               load, start/pause control and a one-cycle terminal pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_countdown_timer (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_load,
  input  logic [7:0] i_load_val,
  input  logic       i_start,
  input  logic       i_pause,
  input  logic       i_tick,
  output logic [7:0] o_count,
  output logic       o_running,
  output logic       o_done
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [7:0] C_ZERO = 8'h00;
  localparam logic [7:0] C_ONE  = 8'h01;

  state_t     r_state;
  logic [7:0] r_count;
  logic       r_running;
  logic       r_done;

  logic [7:0] w_load_san;
  logic [7:0] w_count_dec;

  // Out-of-range digits saturate to 9 so the count is always valid BCD.
  always_comb begin
    w_load_san[7:4] = (i_load_val[7:4] > 4'd9) ? 4'd9 : i_load_val[7:4];
    w_load_san[3:0] = (i_load_val[3:0] > 4'd9) ? 4'd9 : i_load_val[3:0];
  end

  always_comb begin
    w_count_dec = r_count;
    if (r_count != C_ZERO) begin
      if (r_count[3:0] == 4'd0) begin
        w_count_dec = {r_count[7:4] - 4'd1, 4'd9};
      end else begin
        w_count_dec = {r_count[7:4], r_count[3:0] - 4'd1};
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_count   <= C_ZERO;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_load) begin
            r_count <= w_load_san;
          end else if (i_start) begin
            if (r_count == C_ZERO) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_RUN;
              r_running <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (i_pause) begin
            r_state   <= S_PAUSED;
            r_running <= 1'b0;
          end else if (i_tick) begin
            // Last tick lands on 00 together with the done pulse.
            if (r_count == C_ONE) begin
              r_count   <= C_ZERO;
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else begin
              r_count <= w_count_dec;
            end
          end
        end
        S_PAUSED: begin
          if (i_load) begin
            r_count <= w_load_san;
            r_state <= S_IDLE;
          end else if (i_start) begin
            r_state   <= S_RUN;
            r_running <= 1'b1;
          end
        end
        S_DONE: begin
          if (i_load) begin
            r_count <= w_load_san;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign o_count   = r_count;
  assign o_running = r_running;
  assign o_done    = r_done;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ============================================================================
// Module      : tb_bcd_countdown_timer
// Description : Directed and randomized checks of bcd_countdown_timer against
//               a decimal-valued reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [7:0] load_val;
  logic       start;
  logic       pause;
  logic       tick;
  logic [7:0] count;
  logic       running;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: value as a plain integer 0..99, mode 0=idle 1=run 2=paused 3=done.
  int m_val;
  int m_mode;
  bit m_done;

  bcd_countdown_timer u_dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (load),
    .i_load_val (load_val),
    .i_start    (start),
    .i_pause    (pause),
    .i_tick     (tick),
    .o_count    (count),
    .o_running  (running),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] t;
    logic [3:0] o;
    t = 4'(v / 10);
    o = 4'(v % 10);
    return {t, o};
  endfunction

  function automatic int san_val(input logic [7:0] lv);
    int t;
    int o;
    t = (lv[7:4] > 4'd9) ? 9 : int'(lv[7:4]);
    o = (lv[3:0] > 4'd9) ? 9 : int'(lv[3:0]);
    return t * 10 + o;
  endfunction

  task automatic model_reset();
    m_val  = 0;
    m_mode = 0;
    m_done = 1'b0;
  endtask

  task automatic model_clock();
    m_done = 1'b0;
    case (m_mode)
      0: begin
        if (load) m_val = san_val(load_val);
        else if (start) begin
          if (m_val == 0) begin m_mode = 3; m_done = 1'b1; end
          else m_mode = 1;
        end
      end
      1: begin
        if (pause) m_mode = 2;
        else if (tick && m_val > 0) begin
          m_val = m_val - 1;
          if (m_val == 0) begin m_mode = 3; m_done = 1'b1; end
        end
      end
      2: begin
        if (load) begin m_val = san_val(load_val); m_mode = 0; end
        else if (start) m_mode = 1;
      end
      default: begin
        if (load) begin m_val = san_val(load_val); m_mode = 0; end
      end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_eq("count", {24'd0, count}, {24'd0, to_bcd(m_val)});
    check_eq("running", {31'd0, running}, {31'd0, (m_mode == 1)});
    check_eq("done", {31'd0, done}, {31'd0, m_done});
    check_eq("run_done_excl", {31'd0, running & done}, 32'd0);
  endtask

  task automatic idle_in();
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; load_val = 8'h00;
    idle_in();
    model_reset();
    #22;
    check_eq("rst_count", {24'd0, count}, 32'h00);
    check_eq("rst_running", {31'd0, running}, 32'd0);
    check_eq("rst_done", {31'd0, done}, 32'd0);
    reset = 1'b0;

    // Count 12 down to 00 with tick held.
    load_val = 8'h12; load = 1'b1; step();
    check_eq("load12", {24'd0, count}, 32'h12);
    load = 1'b0; start = 1'b1; step();
    check_eq("start_run", {31'd0, running}, 32'd1);
    start = 1'b0; tick = 1'b1;
    repeat (12) step();
    check_eq("end00", {24'd0, count}, 32'h00);
    check_eq("end_done", {31'd0, done}, 32'd1);
    check_eq("end_run", {31'd0, running}, 32'd0);
    repeat (2) step();
    check_eq("after_done", {31'd0, done}, 32'd0);

    // Ones-digit borrow.
    idle_in(); load_val = 8'h20; load = 1'b1; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0; tick = 1'b1; step();
    check_eq("borrow19", {24'd0, count}, 32'h19);
    repeat (10) step();
    check_eq("cnt09", {24'd0, count}, 32'h09);
    repeat (9) step();

    // Pause beats tick; resume cycle does not decrement.
    idle_in(); load_val = 8'h37; load = 1'b1; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0; pause = 1'b1; tick = 1'b1; step();
    check_eq("pause37", {24'd0, count}, 32'h37);
    pause = 1'b0;
    repeat (3) step();
    check_eq("paused_hold", {24'd0, count}, 32'h37);
    start = 1'b1; step();
    check_eq("resume37", {24'd0, count}, 32'h37);
    check_eq("resume_run", {31'd0, running}, 32'd1);
    start = 1'b0; step();
    check_eq("resume36", {24'd0, count}, 32'h36);
    idle_in(); pause = 1'b1; step();
    pause = 1'b0; load_val = 8'h00; load = 1'b1; step();

    // Load beats start in IDLE, with sanitizing.
    idle_in(); load_val = 8'hAB; load = 1'b1; start = 1'b1; step();
    check_eq("san99", {24'd0, count}, 32'h99);
    check_eq("san_norun", {31'd0, running}, 32'd0);
    load = 1'b0; step();
    check_eq("start_after", {31'd0, running}, 32'd1);

    // Start at 00 from IDLE gives a done pulse only.
    idle_in(); pause = 1'b1; step();
    pause = 1'b0; load_val = 8'h00; load = 1'b1; step();
    load = 1'b0; start = 1'b1; step();
    check_eq("zero_done", {31'd0, done}, 32'd1);
    check_eq("zero_norun", {31'd0, running}, 32'd0);
    start = 1'b0; step();
    check_eq("zero_done_off", {31'd0, done}, 32'd0);
    load_val = 8'h05; load = 1'b1; step();
    check_eq("load05", {24'd0, count}, 32'h05);

    // Asynchronous reset mid-count.
    idle_in(); load_val = 8'h45; load = 1'b1; step();
    load = 1'b0; start = 1'b1; step();
    start = 1'b0;
    @(posedge clk);
    model_clock();
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_eq("arst_count", {24'd0, count}, 32'h00);
    check_eq("arst_running", {31'd0, running}, 32'd0);
    check_eq("arst_done", {31'd0, done}, 32'd0);
    #1 reset = 1'b0;
    start = 1'b1; step();
    check_eq("arst_start_run", {31'd0, running}, 32'd0);
    check_eq("arst_start_cnt", {24'd0, count}, 32'h00);
    start = 1'b0; load_val = 8'h03; load = 1'b1; step();
    check_eq("arst_load03", {24'd0, count}, 32'h03);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      load     = ($urandom_range(0, 9) == 0);
      start    = ($urandom_range(0, 3) == 0);
      pause    = ($urandom_range(0, 7) == 0);
      tick     = ($urandom_range(0, 1) == 1);
      load_val = 8'($urandom());
      if ($urandom_range(0, 1) == 1) load_val = to_bcd(int'($urandom_range(0, 15)));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
